// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow asynchronous input in clk cycles,
// with lock detection on a stable period and a sticky loss-of-input timeout.
module clk_period_meter #(
    parameter int WIDTH      = 16,
    parameter int LOCK_COUNT = 4,
    parameter int TOLERANCE  = 1,
    parameter int TIMEOUT    = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sigIn,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] highTime,
    output logic             measValid,
    output logic             locked,
    output logic             timeout
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_COUNT);
    localparam logic [WIDTH-1:0] T_MAX = WIDTH'(TIMEOUT);
    localparam logic [WIDTH:0] TOL = (WIDTH+1)'(TOLERANCE);

    typedef enum logic [1:0] {IDLE, FIRST, MEAS} state_t;

    state_t state, stateNext;
    logic sync0, sync1, sync2;
    logic rise, fall, isMatch;
    logic [WIDTH-1:0] cnt, hiLatch, prevPeriod, prevNext, periodNext, highNext;
    logic [WIDTH:0] diff;
    logic [MW-1:0] matchCnt, matchNext, matchInc;
    logic validNext, lockedNext, timeoutNext;

    assign rise = sync1 & ~sync2;
    assign fall = ~sync1 & sync2;
    // Unsigned magnitude at WIDTH+1 bits so the subtraction never wraps
    assign diff = (cnt >= prevPeriod) ? {1'b0, cnt} - {1'b0, prevPeriod} : {1'b0, prevPeriod} - {1'b0, cnt};
    assign isMatch = diff <= TOL;
    assign matchInc = (matchCnt == LOCK_MAX) ? LOCK_MAX : matchCnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            {sync0, sync1, sync2} <= 3'b111;
            cnt <= '0;
            hiLatch <= '0;
        end else begin
            {sync0, sync1, sync2} <= {sigIn, sync0, sync1};
            cnt <= rise ? WIDTH'(1) : (cnt == T_MAX) ? cnt : cnt + 1'b1;
            if (fall) hiLatch <= cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            period <= '0;
            highTime <= '0;
            measValid <= 1'b0;
            locked <= 1'b0;
            timeout <= 1'b0;
            matchCnt <= '0;
            prevPeriod <= '0;
        end else begin
            state <= stateNext;
            period <= periodNext;
            highTime <= highNext;
            measValid <= validNext;
            locked <= lockedNext;
            timeout <= timeoutNext;
            matchCnt <= matchNext;
            prevPeriod <= prevNext;
        end
    end

    always_comb begin
        stateNext = state;
        periodNext = period;
        highNext = highTime;
        validNext = 1'b0;
        lockedNext = locked;
        timeoutNext = timeout;
        matchNext = matchCnt;
        prevNext = prevPeriod;
        if (rise) begin
            timeoutNext = 1'b0;
            stateNext = (state == IDLE) ? FIRST : MEAS;
            if (state != IDLE) begin
                periodNext = cnt;
                highNext = hiLatch;
                validNext = 1'b1;
                prevNext = cnt;
                matchNext = (state == MEAS && isMatch) ? matchInc : '0;
                lockedNext = (state == MEAS && isMatch && matchInc == LOCK_MAX);
            end
        end else if (state != IDLE && cnt == T_MAX - 1'b1) begin
            stateNext = IDLE;
            timeoutNext = 1'b1;
            lockedNext = 1'b0;
            matchNext = '0;
        end
    end
endmodule
